// File: rtl/pim_mem_pkg.sv
// Shared types for the PIM memory subsystem.
// Holds the default RAM geometry, the requester command record, the owner
// tag used to route read data back to the right requester, and the entry
// type of the read-tag pipeline.
package pim_mem_pkg;

  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W   = MEM_DATA_W / 8;

  // Which requester issued a RAM operation.
  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_PIM  = 1'b1
  } owner_e;

  // One requester command as seen by the RAM, at the default geometry.
  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_BE_W-1:0]   be;
  } mem_req_t;

  // One slot of the read-tag pipeline.
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

  // The requester that is not 'o'.
  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_CORE) ? OWN_PIM : OWN_CORE;
  endfunction

endpackage

// File: rtl/ram_arb_rd_tracker.sv
// Read-tag pipeline for ram_arbiter.
// A read is pushed in the cycle it is granted; its tag walks DEPTH stages and
// pops out in the cycle the RAM presents its data on q. One push per cycle is
// accepted, so back-to-back reads run at full throughput without stalls.
// Ports:
//   clk, reset         clock and synchronous active-high reset (flushes tags)
//   push, push_owner   a read was granted this cycle, and to whom
//   pop_core, pop_pim  the read data on q this cycle belongs to that owner
module ram_arb_rd_tracker
  import pim_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  owner_e push_owner,
  output logic   pop_core,
  output logic   pop_pim
);

  rd_tag_t tags_q [DEPTH];
  rd_tag_t tags_d [DEPTH];

  always_comb begin
    tags_d[0].valid = push;
    tags_d[0].owner = push_owner;
    for (int i = 1; i < DEPTH; i++) begin
      tags_d[i] = tags_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tags_q[i] <= '0;
      end
    end else begin
      tags_q <= tags_d;
    end
  end

  assign pop_core = tags_q[DEPTH-1].valid && (tags_q[DEPTH-1].owner == OWN_CORE);
  assign pop_pim  = tags_q[DEPTH-1].valid && (tags_q[DEPTH-1].owner == OWN_PIM);

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of the single-port RAM1_IP.
// Port 0 is the core-side ram_controller, port 1 the PIM compute engine.
// At most one request is granted per cycle (combinational gnt); the granted
// command is registered onto the ram_* outputs the following cycle, and read
// data returning on ram_q is steered to its owner using a tag pipeline.
// Parameters: ADDR_W, DATA_W, RD_LATENCY (1..3), ARB_MODE (0 round-robin,
// 1 fixed priority with port 0 winning).
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   mN_req/we/addr/wdata/be         requester command, held until mN_gnt
//   mN_gnt                          command accepted this cycle
//   mN_rvalid, mN_rdata             read return pulse and data (data holds)
//   ram_addr/wdata/byteena/wren/rden  registered command into RAM1_IP
//   ram_q                           RAM1_IP read data
// Build option: define RAM_ARB_STATS_EN to add the stat_gnt0, stat_gnt1 and
// stat_conflict counters.
module ram_arbiter
  import pim_mem_pkg::*;
#(
  parameter  int ADDR_W     = MEM_ADDR_W,
  parameter  int DATA_W     = MEM_DATA_W,
  parameter  int RD_LATENCY = 1,
  parameter  int ARB_MODE   = 0,
  localparam int BE_W       = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [BE_W-1:0]   m0_be,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [BE_W-1:0]   m1_be,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [BE_W-1:0]   ram_byteena,
  output logic              ram_wren,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_gnt0,
  output logic [31:0]       stat_gnt1,
  output logic [31:0]       stat_conflict
`endif
);

  owner_e            rr_prio_q, rr_prio_d;
  logic              gnt0, gnt1, gnt_any, contested;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;

  logic              ram_wren_q, ram_wren_d;
  logic              ram_rden_q, ram_rden_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [BE_W-1:0]   ram_byteena_q, ram_byteena_d;

  logic              pop_core, pop_pim;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  // Grants are suppressed while reset is high: a command accepted in that
  // cycle would be wiped from the command register before reaching the RAM.
  // The round-robin pointer names the port that wins the next contested
  // cycle and only moves when both ports actually competed.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    contested = m0_req && m1_req && !reset;
    if (!reset) begin
      if (m0_req && (!m1_req || ARB_MODE == 1 || rr_prio_q == OWN_CORE)) begin
        gnt0 = 1'b1;
      end else if (m1_req) begin
        gnt1 = 1'b1;
      end
    end
    rr_prio_d = rr_prio_q;
    if (contested) begin
      rr_prio_d = other_owner(gnt0 ? OWN_CORE : OWN_PIM);
    end
  end

  assign gnt_any = gnt0 || gnt1;

  // Next RAM command. Reads always enable every byte; idle cycles keep the
  // last address and data on the bus so RAM inputs do not toggle needlessly.
  always_comb begin
    sel_we        = gnt1 ? m1_we    : m0_we;
    sel_addr      = gnt1 ? m1_addr  : m0_addr;
    sel_wdata     = gnt1 ? m1_wdata : m0_wdata;
    sel_be        = gnt1 ? m1_be    : m0_be;
    ram_wren_d    = 1'b0;
    ram_rden_d    = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    ram_byteena_d = ram_byteena_q;
    if (gnt_any) begin
      ram_wren_d    = sel_we;
      ram_rden_d    = !sel_we;
      ram_addr_d    = sel_addr;
      ram_wdata_d   = sel_wdata;
      ram_byteena_d = sel_we ? sel_be : '1;
    end
  end

  // A read pushed at grant time leaves the tracker RD_LATENCY cycles after
  // its command cycle, exactly when ram_q carries its data.
  ram_arb_rd_tracker #(
    .DEPTH(1 + RD_LATENCY)
  ) u_rd_tracker (
    .clk       (clk),
    .reset     (reset),
    .push      (gnt_any && !sel_we),
    .push_owner(gnt1 ? OWN_PIM : OWN_CORE),
    .pop_core  (pop_core),
    .pop_pim   (pop_pim)
  );

  // Returns landing in a reset cycle belong to reads being discarded.
  // rdata shows ram_q live during the rvalid pulse and then holds it.
  always_comb begin
    rvalid0  = pop_core && !reset;
    rvalid1  = pop_pim && !reset;
    rdata0_d = rvalid0 ? ram_q : rdata0_q;
    rdata1_d = rvalid1 ? ram_q : rdata1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_prio_q     <= OWN_CORE;
      ram_wren_q    <= 1'b0;
      ram_rden_q    <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      ram_byteena_q <= '0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
    end else begin
      rr_prio_q     <= rr_prio_d;
      ram_wren_q    <= ram_wren_d;
      ram_rden_q    <= ram_rden_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      ram_byteena_q <= ram_byteena_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
    end
  end

  assign m0_gnt      = gnt0;
  assign m1_gnt      = gnt1;
  assign m0_rvalid   = rvalid0;
  assign m1_rvalid   = rvalid1;
  assign m0_rdata    = rdata0_d;
  assign m1_rdata    = rdata1_d;
  assign ram_wren    = ram_wren_q;
  assign ram_rden    = ram_rden_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign ram_byteena = ram_byteena_q;

`ifdef RAM_ARB_STATS_EN
  // Free-running grant and conflict counters; they wrap naturally.
  logic [31:0] stat_gnt0_q, stat_gnt0_d;
  logic [31:0] stat_gnt1_q, stat_gnt1_d;
  logic [31:0] stat_conflict_q, stat_conflict_d;

  always_comb begin
    stat_gnt0_d     = stat_gnt0_q + (gnt0 ? 32'd1 : 32'd0);
    stat_gnt1_d     = stat_gnt1_q + (gnt1 ? 32'd1 : 32'd0);
    stat_conflict_d = stat_conflict_q + (contested ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_gnt0_q     <= '0;
      stat_gnt1_q     <= '0;
      stat_conflict_q <= '0;
    end else begin
      stat_gnt0_q     <= stat_gnt0_d;
      stat_gnt1_q     <= stat_gnt1_d;
      stat_conflict_q <= stat_conflict_d;
    end
  end

  assign stat_gnt0     = stat_gnt0_q;
  assign stat_gnt1     = stat_gnt1_q;
  assign stat_conflict = stat_conflict_q;
`else
  // Statistics counters are not built; arbitration is unaffected.
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed scenarios with literal expectations,
// then randomized two-port traffic checked every cycle against a
// transaction-level model of arbitration, the RAM contents and read returns.
// A second instance built with fixed priority covers that mode.
module tb_ram_arbiter;

  localparam int AW     = 10;
  localparam int DW     = 32;
  localparam int BW     = 4;
  localparam int RD_LAT = 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic [BW-1:0] m0_be = '0;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic [BW-1:0] m1_be = '0;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [BW-1:0] ram_byteena;
  logic          ram_wren, ram_rden;
  logic [DW-1:0] ram_q = '0;

  logic          f_req0 = 1'b0, f_req1 = 1'b0;
  logic          f_gnt0, f_gnt1, f_rv0, f_rv1;
  logic [DW-1:0] f_rd0, f_rd1;
  logic [AW-1:0] f_ram_addr;
  logic [DW-1:0] f_ram_wdata;
  logic [BW-1:0] f_ram_byteena;
  logic          f_ram_wren, f_ram_rden;
  logic [DW-1:0] f_ram_q = '0;

`ifdef RAM_ARB_STATS_EN
  logic [31:0] stat_gnt0, stat_gnt1, stat_conflict;
  logic [31:0] f_stat_gnt0, f_stat_gnt1, f_stat_conflict;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RD_LAT), .ARB_MODE(0)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_byteena(ram_byteena),
    .ram_wren(ram_wren), .ram_rden(ram_rden), .ram_q(ram_q)
`ifdef RAM_ARB_STATS_EN
    , .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_conflict(stat_conflict)
`endif
  );

  ram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RD_LAT), .ARB_MODE(1)
  ) u_fix (
    .clk(clk), .reset(reset),
    .m0_req(f_req0), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(f_gnt0), .m0_rvalid(f_rv0), .m0_rdata(f_rd0),
    .m1_req(f_req1), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(f_gnt1), .m1_rvalid(f_rv1), .m1_rdata(f_rd1),
    .ram_addr(f_ram_addr), .ram_wdata(f_ram_wdata), .ram_byteena(f_ram_byteena),
    .ram_wren(f_ram_wren), .ram_rden(f_ram_rden), .ram_q(f_ram_q)
`ifdef RAM_ARB_STATS_EN
    , .stat_gnt0(f_stat_gnt0), .stat_gnt1(f_stat_gnt1), .stat_conflict(f_stat_conflict)
`endif
  );

  // Behavioural single-port RAM with one cycle of read latency.
  logic [DW-1:0] mem [1024] = '{default: '0};
  always @(posedge clk) begin
    if (ram_wren) begin
      for (int b = 0; b < BW; b++) begin
        if (ram_byteena[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
    if (ram_rden) ram_q <= mem[ram_addr];
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int port, input bit req, input bit we,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input logic [BW-1:0] be);
    if (port == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be;
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    int            port;
    int            due;
    logic [DW-1:0] data;
  } resp_t;

  logic [DW-1:0] shadow [1024] = '{default: '0};
  resp_t         rq [$];
  int            cyc = 0;
  bit            mdl_on = 0;
  int            last_win = 1;
  bit            mdl_gnt [2] = '{0, 0};
  logic          exp_wren, exp_rden;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  logic [BW-1:0] exp_be;
  logic [DW-1:0] exp_hold [2];

  always @(negedge clk) begin : cmp_proc
    int            win;
    bit            rv [2];
    bit            w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic [BW-1:0] w_be;
    cyc++;
    if (reset) begin
      checkOutput("gnt0_in_reset", m0_gnt, 0);
      checkOutput("gnt1_in_reset", m1_gnt, 0);
      checkOutput("rvalid0_in_reset", m0_rvalid, 0);
      checkOutput("rvalid1_in_reset", m1_rvalid, 0);
      if (mdl_on) begin
        checkOutput("rdata0_in_reset", m0_rdata, exp_hold[0]);
        checkOutput("rdata1_in_reset", m1_rdata, exp_hold[1]);
      end
      rq.delete();
      exp_wren = 0; exp_rden = 0; exp_addr = '0; exp_wdata = '0; exp_be = '0;
      exp_hold[0] = '0; exp_hold[1] = '0;
      last_win = 1;
      mdl_gnt[0] = 0; mdl_gnt[1] = 0;
      mdl_on = 1;
    end else if (mdl_on) begin
      // Contested cycles go to the port that lost the previous contest.
      if (m0_req && m1_req) begin
        win = 1 - last_win;
        last_win = win;
      end else if (m0_req) win = 0;
      else if (m1_req) win = 1;
      else win = -1;

      rv[0] = 0; rv[1] = 0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        rv[rq[0].port] = 1;
        exp_hold[rq[0].port] = rq[0].data;
        void'(rq.pop_front());
      end

      checkOutput("m0_gnt", m0_gnt, win == 0);
      checkOutput("m1_gnt", m1_gnt, win == 1);
      checkOutput("ram_wren", ram_wren, exp_wren);
      checkOutput("ram_rden", ram_rden, exp_rden);
      checkOutput("ram_addr", ram_addr, exp_addr);
      checkOutput("ram_wdata", ram_wdata, exp_wdata);
      if (exp_wren || exp_rden) checkOutput("ram_byteena", ram_byteena, exp_be);
      checkOutput("m0_rvalid", m0_rvalid, rv[0]);
      checkOutput("m1_rvalid", m1_rvalid, rv[1]);
      checkOutput("m0_rdata", m0_rdata, exp_hold[0]);
      checkOutput("m1_rdata", m1_rdata, exp_hold[1]);

      if (win >= 0) begin
        w_we    = (win == 0) ? m0_we    : m1_we;
        w_addr  = (win == 0) ? m0_addr  : m1_addr;
        w_wdata = (win == 0) ? m0_wdata : m1_wdata;
        w_be    = (win == 0) ? m0_be    : m1_be;
        exp_wren = w_we; exp_rden = !w_we;
        exp_addr = w_addr; exp_wdata = w_wdata;
        exp_be   = w_we ? w_be : 4'hF;
        if (w_we) begin
          for (int b = 0; b < BW; b++) begin
            if (w_be[b]) shadow[w_addr][8*b +: 8] = w_wdata[8*b +: 8];
          end
        end else begin
          rq.push_back('{port: win, due: cyc + 1 + RD_LAT, data: shadow[w_addr]});
        end
      end else begin
        exp_wren = 0; exp_rden = 0;
      end
      mdl_gnt[0] = (win == 0);
      mdl_gnt[1] = (win == 1);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : driver
    int  cnt0, cnt1;
    bit  busy [2];
    busy[0] = 0; busy[1] = 0;

    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    checkOutput("rst_ram_cmd", {ram_wren, ram_rden, ram_addr, ram_wdata, ram_byteena}, 0);
    checkOutput("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    checkOutput("rst_rdata0", m0_rdata, 0);
    nextCycle();

    // Port 0 alone: write then read back.
    applyStimulus(0, 1, 1, 10'h005, 32'hDEADBEEF, 4'hF);
    @(negedge clk); checkOutput("t1_wr_gnt", m0_gnt, 1);
    nextCycle();
    applyStimulus(0, 1, 0, 10'h005, 32'h0, 4'h0);
    @(negedge clk); checkOutput("t1_rd_gnt", m0_gnt, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 10'h000, 32'h0, 4'h0);
    @(negedge clk); checkOutput("t1_rvalid_early", m0_rvalid, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("t1_rvalid", m0_rvalid, 1);
    checkOutput("t1_rdata", m0_rdata, 32'hDEADBEEF);
    checkOutput("t1_m1_rvalid", m1_rvalid, 0);
    nextCycle();

    // Byte mask merge.
    applyStimulus(0, 1, 1, 10'h010, 32'hFFFFFFFF, 4'hF);
    nextCycle();
    applyStimulus(0, 1, 1, 10'h010, 32'h00000000, 4'b0101);
    @(negedge clk); checkOutput("t2_be_cmd", ram_byteena, 4'hF);
    nextCycle();
    applyStimulus(0, 1, 0, 10'h010, 32'h0, 4'h0);
    @(negedge clk); checkOutput("t2_be_mask", ram_byteena, 4'b0101);
    nextCycle();
    applyStimulus(0, 0, 0, 10'h000, 32'h0, 4'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("t2_rvalid", m0_rvalid, 1);
    checkOutput("t2_rdata", m0_rdata, 32'hFF00FF00);
    nextCycle();

    // Round-robin contention on reads of known data.
    applyStimulus(0, 1, 1, 10'h001, 32'h11111111, 4'hF);
    nextCycle();
    applyStimulus(0, 0, 0, 10'h000, 32'h0, 4'h0);
    applyStimulus(1, 1, 1, 10'h002, 32'h22222222, 4'hF);
    nextCycle();
    applyStimulus(1, 0, 0, 10'h000, 32'h0, 4'h0);
    reset = 1;
    nextCycle();
    reset = 0;
    applyStimulus(0, 1, 0, 10'h001, 32'h0, 4'h0);
    applyStimulus(1, 1, 0, 10'h002, 32'h0, 4'h0);
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 8) begin
        applyStimulus(0, 0, 0, 10'h000, 32'h0, 4'h0);
        applyStimulus(1, 0, 0, 10'h000, 32'h0, 4'h0);
      end
      @(negedge clk);
      if (k < 8) begin
        checkOutput("t3_gnt0", m0_gnt, (k % 2) == 0);
        checkOutput("t3_gnt1", m1_gnt, (k % 2) == 1);
      end
      if (m0_rvalid) begin
        cnt0++;
        checkOutput("t3_rdata0", m0_rdata, 32'h11111111);
      end
      if (m1_rvalid) begin
        cnt1++;
        checkOutput("t3_rdata1", m1_rdata, 32'h22222222);
      end
`ifdef RAM_ARB_STATS_EN
      if (k == 8) begin
        checkOutput("t6_stat_gnt0", stat_gnt0, 4);
        checkOutput("t6_stat_gnt1", stat_gnt1, 4);
        checkOutput("t6_stat_conflict", stat_conflict, 8);
      end
`endif
      nextCycle();
    end
    checkOutput("t3_count0", cnt0, 4);
    checkOutput("t3_count1", cnt1, 4);

    // Fixed priority instance.
    applyStimulus(0, 0, 1, 10'h020, 32'h0, 4'hF);
    applyStimulus(1, 0, 1, 10'h021, 32'h0, 4'hF);
    f_req0 = 1; f_req1 = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("t4_fix_gnt0", f_gnt0, 1);
      checkOutput("t4_fix_gnt1", f_gnt1, 0);
      checkOutput("t4_fix_rvalid", {f_rv0, f_rv1}, 0);
      nextCycle();
    end
    f_req0 = 0;
    @(negedge clk);
    checkOutput("t4_fix_gnt1_after", f_gnt1, 1);
    checkOutput("t4_fix_gnt0_after", f_gnt0, 0);
    checkOutput("t4_fix_rdata", {f_rd0, f_rd1}, 0);
    nextCycle();
    f_req1 = 0;

    // Reset while a read is in flight.
    applyStimulus(0, 1, 0, 10'h005, 32'h0, 4'h0);
    @(negedge clk); checkOutput("t5_rd_gnt", m0_gnt, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 10'h000, 32'h0, 4'h0);
    reset = 1;
    nextCycle();
    reset = 0;
    @(negedge clk);
    checkOutput("t5_ram_cmd", {ram_wren, ram_rden, ram_addr, ram_wdata, ram_byteena}, 0);
    checkOutput("t5_fix_ram_cmd", {f_ram_wren, f_ram_rden, f_ram_addr, f_ram_wdata, f_ram_byteena}, 0);
    checkOutput("t5_rvalid", {m0_rvalid, m1_rvalid}, 0);
    checkOutput("t5_rdata0", m0_rdata, 0);
    nextCycle();
    @(negedge clk); checkOutput("t5_rvalid_late", {m0_rvalid, m1_rvalid}, 0);
    nextCycle();

    // Randomized traffic; requesters hold until the model says granted.
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (busy[p] && mdl_gnt[p]) busy[p] = 0;
        if (busy[p] && $urandom_range(0, 19) == 0) begin
          busy[p] = 0;
          applyStimulus(p, 0, 0, 10'h000, 32'h0, 4'h0);
        end else if (!busy[p] && $urandom_range(0, 3) != 0) begin
          busy[p] = 1;
          applyStimulus(p, 1, $urandom_range(0, 1) == 1, 10'($urandom_range(0, 15)),
                        $urandom, 4'($urandom_range(0, 15)));
        end else if (!busy[p]) begin
          applyStimulus(p, 0, 0, 10'h000, 32'h0, 4'h0);
        end
      end
      reset = ($urandom_range(0, 199) == 0);
      nextCycle();
    end
    reset = 0;
    applyStimulus(0, 0, 0, 10'h000, 32'h0, 4'h0);
    applyStimulus(1, 0, 0, 10'h000, 32'h0, 4'h0);
    repeat (5) nextCycle();
    checkOutput("drain_pending", rq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
